// File: rtl/njp_micro_divider_if.sv
// Operand/result bundle for the micro divider: the requester drives start and
// operands, the divider returns status and the registered quotient/remainder.
interface njp_micro_divider_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/njp_micro_divider.sv
// Sequential restoring divider: one quotient bit per clock, results held
// registered until the next completion. Divide-by-zero short-circuits to DONE.
module njp_micro_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  njp_micro_divider_if.slave bus
);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] d;        // dividend shifts out the top, quotient bits shift in the bottom
  logic [VW-1:0] v;
  logic [VW-1:0] r;        // partial remainder; always < V, so the extra bit lives only in the trial
  logic [CW-1:0] cnt;

  logic          busy_r;
  logic          done_r;
  logic          dz_r;
  logic [DW-1:0] quo_r;
  logic [VW-1:0] rem_r;

  logic [VW:0]   trial;
  logic          ge;
  logic [VW-1:0] r_next;
  logic [DW-1:0] d_next;

  always_comb begin
    trial  = {r, d[DW-1]};
    ge     = (trial >= {1'b0, v});
    r_next = ge ? VW'(trial - {1'b0, v}) : trial[VW-1:0];
    d_next = {d[DW-2:0], ge};
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      d      <= '0;
      v      <= '0;
      r      <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      quo_r  <= '0;
      rem_r  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              d      <= bus.dividend;
              v      <= bus.divisor;
              r      <= '0;
              cnt    <= CW'(DW);
              busy_r <= 1'b1;
              state  <= S_RUN;
            end else begin
              quo_r  <= '1;
              rem_r  <= '0;
              dz_r   <= 1'b1;
              done_r <= 1'b1;
              state  <= S_DONE;
            end
          end
        end

        S_RUN: begin
          d   <= d_next;
          r   <= r_next;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            quo_r  <= d_next;
            rem_r  <= r_next;
            dz_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= S_DONE;
          end
        end

        S_DONE: begin
          done_r <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quo_r;
  assign bus.remainder = rem_r;
  assign bus.div_zero  = dz_r;
endmodule

// File: tb/tb_njp_micro_divider.sv
// Self-checking bench for njp_micro_divider: directed cases with literal
// expectations plus a full randomized operand sweep against a timeline model.
module tb_njp_micro_divider;
  localparam int DW = 8;
  localparam int VW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  njp_micro_divider_if #(.DW(DW), .VW(VW)) bus ();

  njp_micro_divider #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: tracks when the divider is free, when a result is due,
  // and what the visible outputs must be, using plain integer division.
  int edge_n  = 0;
  int due     = 0;
  int free_at = 0;
  bit pend    = 0;
  bit model_on = 0;
  int pq, pr;
  bit exp_busy, exp_done, exp_dz;
  int exp_q, exp_r;

  always @(posedge clk) begin
    edge_n++;
    model_on = 1;
    if (!rst_n) begin
      exp_busy = 0; exp_done = 0; exp_dz = 0; exp_q = 0; exp_r = 0;
      pend = 0;
      free_at = edge_n + 1;
    end else begin
      exp_done = 0;
      if (pend && edge_n == due) begin
        exp_q = pq; exp_r = pr; exp_dz = 0;
        exp_done = 1; exp_busy = 0; pend = 0;
        free_at = edge_n + 2;
      end else if (!pend && edge_n >= free_at && bus.start === 1'b1) begin
        if (int'(bus.divisor) == 0) begin
          exp_q = (1 << DW) - 1; exp_r = 0; exp_dz = 1; exp_done = 1;
          free_at = edge_n + 2;
        end else begin
          pq = int'(bus.dividend) / int'(bus.divisor);
          pr = int'(bus.dividend) % int'(bus.divisor);
          due = edge_n + DW;
          pend = 1;
          exp_busy = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("busy", bus.busy, exp_busy);
      check("done", bus.done, exp_done);
      check("quotient", bus.quotient, exp_q);
      check("remainder", bus.remainder, exp_r);
      check("div_zero", bus.div_zero, exp_dz);
    end
  end

  // One operation: present start, scramble operands after capture, optionally
  // re-pulse start mid-RUN, then check latency, busy length and result.
  task automatic do_op(input int a, input int b, input bit lit,
                       input int eq, input int er, input int edz, input int poke);
    int cyc, busy_cnt;
    bit seen;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = DW'(a); bus.divisor = VW'(b);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = DW'($urandom); bus.divisor = VW'($urandom);
    cyc = 1; busy_cnt = 0; seen = 0;
    while (!seen && cyc <= DW + 4) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1;
      else begin
        if (bus.busy === 1'b1) busy_cnt++;
        @(posedge clk); #1;
        bus.start = (cyc == poke);
        if (cyc == poke) begin
          bus.dividend = DW'($urandom);
          bus.divisor  = VW'($urandom_range(1, 15));
        end
        cyc++;
      end
    end
    bus.start = 1'b0;
    check("done_seen", 32'(seen), 1);
    check("latency", cyc, (b == 0) ? 1 : DW + 1);
    check("busy_cycles", busy_cnt, (b == 0) ? 0 : DW);
    if (lit) begin
      check("lit_quotient", bus.quotient, eq);
      check("lit_remainder", bus.remainder, er);
      check("lit_div_zero", bus.div_zero, edz);
    end
    if (b != 0 && seen) begin
      check("invariant", int'(bus.quotient) * b + int'(bus.remainder), a);
      check("rem_lt_div", 32'(int'(bus.remainder) < b), 1);
    end
  endtask

  initial begin
    int done_cnt;
    int off;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_div_zero", bus.div_zero, 0);

    do_op(200, 7, 1, 28, 4, 0, -1);
    do_op(255, 15, 1, 17, 0, 0, -1);
    do_op(5, 9, 1, 0, 5, 0, -1);
    do_op(0, 1, 1, 0, 0, 0, -1);
    do_op(255, 1, 1, 255, 0, 0, -1);

    do_op(77, 0, 1, 255, 0, 1, -1);
    do_op(10, 3, 1, 3, 1, 0, -1);

    do_op(200, 7, 1, 28, 4, 0, 3);

    // Reset asserted for one edge in the middle of an operation.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 8'd123; bus.divisor = 4'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", bus.busy, 0);
    check("midrst_quotient", bus.quotient, 0);
    check("midrst_remainder", bus.remainder, 0);
    check("midrst_div_zero", bus.div_zero, 0);
    done_cnt = 0;
    for (int i = 0; i < DW + 3; i++) begin
      if (bus.done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    check("midrst_no_done", done_cnt, 0);
    do_op(100, 6, 1, 16, 4, 0, -1);

    // Every operand pair once, in a shuffled order, with random gaps and pokes.
    off = int'($urandom_range(0, 4095));
    for (int i = 0; i < 4096; i++) begin
      int k, a, b, poke;
      k = (i * 2053 + off) % 4096;
      a = k >> 4;
      b = k & 15;
      poke = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, DW - 1)) : -1;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_op(a, b, 0, 0, 0, 0, poke);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
    $fatal(1, "watchdog expired");
  end
endmodule
